mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an I-cache
// (read-only) and a D-cache requester; every output comes straight from a register.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, IC_BUSY, DC_BUSY, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_ready_q, ic_ready_d;
    logic              dc_ready_q, dc_ready_d;
    logic              dc_req, grant_dc, grant_ic, done;

    // On a tie the D-cache wins unless it was the last one served.
    assign dc_req   = dc_read | dc_write;
    assign grant_dc = (state_q == IDLE) && dc_req && (!ic_read || !last_dc_q);
    assign grant_ic = (state_q == IDLE) && ic_read && !grant_dc;
    assign done     = (state_q == IC_BUSY || state_q == DC_BUSY) && mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_dc ? DC_BUSY : grant_ic ? IC_BUSY : IDLE;
            IC_BUSY,
            DC_BUSY: state_d = mem_ready ? RELEASE : state_q;
            default: state_d = IDLE;
        endcase
    end

    // The mem_* registers double as the request latch, so they ignore
    // requester inputs until the transaction completes.
    always_comb begin
        last_dc_d   = last_dc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        if (grant_dc) begin
            mem_read_d  = !dc_write;
            mem_write_d = dc_write;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
        end else if (grant_ic) begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = ic_addr;
        end
        if (done) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            last_dc_d   = (state_q == DC_BUSY);
            if (state_q == IC_BUSY) begin
                ic_rdata_d = mem_rdata;
                ic_ready_d = 1'b1;
            end else begin
                dc_rdata_d = mem_write_q ? dc_rdata_q : mem_rdata;
                dc_ready_d = 1'b1;
            end
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter; inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_read, dc_read, dc_write, mem_ready;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [DW-1:0] dc_wdata, mem_rdata;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          ic_ready, dc_ready, mem_read, mem_write;
    int            n_cmp = 0;
    int            n_bad = 0;

    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        ic_read = 0; dc_read = 0; dc_write = 0; mem_ready = 0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        tick();
        do_reset();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ic_rdata", ic_rdata, 0);
        chk("rst_dc_rdata", dc_rdata, 0);
        chk("rst_ic_ready", ic_ready, 0);
        chk("rst_dc_ready", dc_ready, 0);

        // IC read alone, memory answers after three cycles
        ic_read = 1; ic_addr = 28'h0000010; mem_rdata = A5;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ic_mem_read_held", mem_read, 1);
            chk("ic_mem_addr", mem_addr, 28'h0000010);
            chk("ic_ready_low", ic_ready, 0);
            if (i == 2) mem_ready = 1;
            tick();
        end
        chk("ic_done_mem_read", mem_read, 0);
        chk("ic_ready_pulse", ic_ready, 1);
        chk("ic_rdata", ic_rdata, A5);
        chk("ic_no_dc_ready", dc_ready, 0);
        ic_read = 0;
        tick();
        chk("ic_release_ready", ic_ready, 0);
        chk("ic_release_ignores_ready", mem_read, 0);
        tick();
        chk("idle_ignores_ready", mem_read, 0);
        chk("ic_rdata_held", ic_rdata, A5);
        mem_ready = 0;

        // Ties after reset: DC, then IC, then DC
        do_reset();
        ic_read = 1; dc_read = 1; ic_addr = 28'h100; dc_addr = 28'h200; mem_rdata = 128'h1111;
        tick();
        chk("tie1_dc_addr", mem_addr, 28'h200);
        chk("tie1_read", mem_read, 1);
        mem_ready = 1;
        tick();
        chk("tie1_dc_ready", dc_ready, 1);
        chk("tie1_ic_ready", ic_ready, 0);
        chk("tie1_dc_rdata", dc_rdata, 128'h1111);
        mem_ready = 0;
        tick();
        chk("tie1_release_no_grant", mem_read, 0);
        chk("tie1_ready_pulse_end", dc_ready, 0);
        tick();
        chk("tie2_ic_addr", mem_addr, 28'h100);
        chk("tie2_read", mem_read, 1);
        mem_rdata = 128'h2222; mem_ready = 1;
        tick();
        chk("tie2_ic_ready", ic_ready, 1);
        chk("tie2_dc_ready", dc_ready, 0);
        chk("tie2_ic_rdata", ic_rdata, 128'h2222);
        chk("tie2_dc_rdata_held", dc_rdata, 128'h1111);
        mem_ready = 0;
        tick(2);
        chk("tie3_dc_addr", mem_addr, 28'h200);
        mem_rdata = 128'h3333; mem_ready = 1;
        tick();
        chk("tie3_dc_ready", dc_ready, 1);
        chk("tie3_dc_rdata", dc_rdata, 128'h3333);
        ic_read = 0; dc_read = 0; mem_ready = 0;
        tick();

        // DC write leaves dc_rdata untouched
        dc_write = 1; dc_addr = 28'h0000020; dc_wdata = 128'h1234; mem_rdata = 128'hDEAD;
        tick();
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_read", mem_read, 0);
        chk("wr_mem_addr", mem_addr, 28'h20);
        chk("wr_mem_wdata", mem_wdata, 128'h1234);
        mem_ready = 1;
        tick();
        chk("wr_dc_ready", dc_ready, 1);
        chk("wr_dc_rdata_kept", dc_rdata, 128'h3333);
        chk("wr_done", mem_write, 0);
        dc_write = 0; mem_ready = 0;
        tick();
        chk("wr_ready_one_cycle", dc_ready, 0);

        // Read+write together is a write; latched command ignores input churn
        dc_read = 1; dc_write = 1; dc_addr = 28'h0000040; dc_wdata = 128'h5678;
        tick();
        chk("rw_mem_write", mem_write, 1);
        chk("rw_mem_read", mem_read, 0);
        for (int i = 0; i < 5; i++) begin
            dc_addr = 28'h0ABC000 + 28'(i); dc_wdata = 128'(i); dc_write = i[0];
            tick();
            chk("churn_addr", mem_addr, 28'h40);
            chk("churn_wdata", mem_wdata, 128'h5678);
            chk("churn_write", mem_write, 1);
            chk("churn_no_ready", dc_ready, 0);
        end
        mem_ready = 1;
        tick();
        chk("rw_dc_ready", dc_ready, 1);
        dc_read = 0; dc_write = 0; mem_ready = 0;
        tick();

        // Reset in the middle of a DC read aborts it
        dc_read = 1; dc_addr = 28'h0000080;
        tick();
        chk("abort_busy", mem_read, 1);
        rst = 0;
        tick();
        chk("abort_mem_read", mem_read, 0);
        chk("abort_dc_ready", dc_ready, 0);
        chk("abort_mem_addr", mem_addr, 0);
        rst = 1; dc_read = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_ready_dc", dc_ready, 0);
            chk("late_ready_ic", ic_ready, 0);
            chk("late_ready_mem", mem_read, 0);
        end
        mem_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
